pid_ctrl_gen: RTL and testbench

Parametrised four-stage pipelined PID steering controller. It converts a signed heading error and a forward speed command into left and right motor speed commands. Compared with the previous generation, it adds:
- runtime-programmable P and D gains;
- configurable widths and derivative history depth;
- selectable integrator anti-windup mode;
- two-sided output saturation;
- an output valid strobe.

It sits between the heading-error source and the motor PWM drivers.

---
 rtl/pid_ctrl_gen_if.sv | 26 ++
 rtl/pid_ctrl_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_pid_ctrl_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pid_ctrl_gen_if.sv
// Steering-controller sample bus: heading error, speed command and gains in; wheel speeds out.
// The master drives the samples and the slave (controller) returns speeds. There is no ready signal.
interface pid_ctrl_gen_if #(
    parameter int ERR_W = 12,
    parameter int SAT_W = 10
);
    logic                    moving;
    logic                    err_vld;
    logic signed [ERR_W-1:0] error;
    logic [SAT_W-1:0]        frwrd;
    logic [5:0]              kp;
    logic [4:0]              kd;
    logic [SAT_W:0]          lft_spd;
    logic [SAT_W:0]          rght_spd;
    logic                    out_vld;

    modport master (
        output moving, err_vld, error, frwrd, kp, kd,
        input  lft_spd, rght_spd, out_vld
    );

    modport slave (
        input  moving, err_vld, error, frwrd, kp, kd,
        output lft_spd, rght_spd, out_vld
    );
endinterface

// File: rtl/pid_ctrl_gen.sv
// Four-stage PID steering controller: heading error + forward speed -> clamped left/right speeds.
// Latency is 4 cycles. It accepts one sample per cycle and applies no backpressure.
module pid_ctrl_gen #(
    parameter int ERR_W     = 12,
    parameter int SAT_W     = 10,
    parameter int INT_W     = 15,
    parameter int INT_SHIFT = 6,
    parameter int D_HIST    = 3,
    parameter int DSAT_W    = 8,
    parameter int ANTIWIND  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    pid_ctrl_gen_if.slave  pid_io
);

    localparam int P_W   = SAT_W + 7;
    localparam int I_W   = INT_W - INT_SHIFT;
    localparam int D_W   = DSAT_W + 6;
    localparam int PID_W = ((P_W > D_W) ? P_W : D_W) + 1;
    // Wide enough that frwrd +/- adj cannot wrap for any gain setting.
    localparam int SPD_W = ((PID_W > SAT_W + 1) ? PID_W : SAT_W + 1) + 1;

    localparam logic signed [SAT_W-1:0] SAT_MAX = {1'b0, {(SAT_W-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] SAT_MIN = {1'b1, {(SAT_W-1){1'b0}}};
    localparam logic signed [DSAT_W-1:0] DSAT_MAX = {1'b0, {(DSAT_W-1){1'b1}}};
    localparam logic signed [DSAT_W-1:0] DSAT_MIN = {1'b1, {(DSAT_W-1){1'b0}}};
    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [SPD_W-1:0] SPD_MAX = {{(SPD_W-SAT_W){1'b0}}, {SAT_W{1'b1}}};

    // ---------------- stage 1: saturate error, proportional product ----------------
    logic [ERR_W-SAT_W:0]    err_top;
    logic signed [SAT_W-1:0] err_sat_d;
    logic signed [P_W-1:0]   p_d;

    always_comb begin
        err_top = pid_io.error[ERR_W-1:SAT_W-1];
        if (err_top == '0 || err_top == '1) begin
            err_sat_d = pid_io.error[SAT_W-1:0];
        end else begin
            err_sat_d = pid_io.error[ERR_W-1] ? SAT_MIN : SAT_MAX;
        end
        p_d = $signed({{7{err_sat_d[SAT_W-1]}}, err_sat_d})
            * $signed({{(P_W-6){1'b0}}, pid_io.kp});
    end

    logic signed [SAT_W-1:0] err_s1_q;
    logic signed [P_W-1:0]   p_s1_q;
    logic [4:0]              kd_s1_q;
    logic [SAT_W-1:0]        frwrd_s1_q;
    logic                    mov_s1_q;
    logic                    vld_s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_s1_q   <= '0;
            p_s1_q     <= '0;
            kd_s1_q    <= '0;
            frwrd_s1_q <= '0;
            mov_s1_q   <= 1'b0;
            vld_s1_q   <= 1'b0;
        end else begin
            err_s1_q   <= err_sat_d;
            p_s1_q     <= p_d;
            kd_s1_q    <= pid_io.kd;
            frwrd_s1_q <= pid_io.frwrd;
            mov_s1_q   <= pid_io.moving;
            vld_s1_q   <= pid_io.err_vld;
        end
    end

    // ---------------- stage 2: integrator with overflow policy ----------------
    logic signed [INT_W-1:0] integ_q;
    logic signed [INT_W-1:0] err_ext;
    logic signed [INT_W-1:0] sum;
    logic signed [INT_W-1:0] integ_d;
    logic                    ov;

    always_comb begin
        err_ext = {{(INT_W-SAT_W){err_s1_q[SAT_W-1]}}, err_s1_q};
        sum     = integ_q + err_ext;
        ov      = (integ_q[INT_W-1] == err_ext[INT_W-1]) && (sum[INT_W-1] != integ_q[INT_W-1]);
        integ_d = integ_q;
        if (!mov_s1_q) begin
            integ_d = '0;
        end else if (vld_s1_q) begin
            if (!ov) begin
                integ_d = sum;
            end else if (ANTIWIND != 0) begin
                integ_d = integ_q[INT_W-1] ? INT_MIN : INT_MAX;
            end
        end
    end

    logic signed [SAT_W-1:0] err_s2_q;
    logic signed [P_W-1:0]   p_s2_q;
    logic signed [I_W-1:0]   i_s2_q;
    logic [4:0]              kd_s2_q;
    logic [SAT_W-1:0]        frwrd_s2_q;
    logic                    mov_s2_q;
    logic                    vld_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q    <= '0;
            err_s2_q   <= '0;
            p_s2_q     <= '0;
            i_s2_q     <= '0;
            kd_s2_q    <= '0;
            frwrd_s2_q <= '0;
            mov_s2_q   <= 1'b0;
            vld_s2_q   <= 1'b0;
        end else begin
            integ_q    <= integ_d;
            err_s2_q   <= err_s1_q;
            p_s2_q     <= p_s1_q;
            i_s2_q     <= integ_d[INT_W-1:INT_SHIFT];
            kd_s2_q    <= kd_s1_q;
            frwrd_s2_q <= frwrd_s1_q;
            mov_s2_q   <= mov_s1_q;
            vld_s2_q   <= vld_s1_q;
        end
    end

    // ---------------- stage 3: derivative against the D_HIST-th previous valid sample ----------------
    logic [D_HIST-1:0][SAT_W-1:0] hist_q;
    logic signed [SAT_W-1:0]      diff_d;
    logic [SAT_W-DSAT_W:0]        diff_top;
    logic signed [DSAT_W-1:0]     diff_sat_d;
    logic signed [D_W-1:0]        d_d;

    always_comb begin
        diff_d   = err_s2_q - $signed(hist_q[D_HIST-1]);
        diff_top = diff_d[SAT_W-1:DSAT_W-1];
        if (diff_top == '0 || diff_top == '1) begin
            diff_sat_d = diff_d[DSAT_W-1:0];
        end else begin
            diff_sat_d = diff_d[SAT_W-1] ? DSAT_MIN : DSAT_MAX;
        end
        d_d = $signed({{6{diff_sat_d[DSAT_W-1]}}, diff_sat_d})
            * $signed({{(D_W-5){1'b0}}, kd_s2_q});
    end

    logic signed [D_W-1:0]   d_s3_q;
    logic signed [P_W-1:0]   p_s3_q;
    logic signed [I_W-1:0]   i_s3_q;
    logic [SAT_W-1:0]        frwrd_s3_q;
    logic                    mov_s3_q;
    logic                    vld_s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            d_s3_q     <= '0;
            p_s3_q     <= '0;
            i_s3_q     <= '0;
            frwrd_s3_q <= '0;
            mov_s3_q   <= 1'b0;
            vld_s3_q   <= 1'b0;
        end else begin
            if (vld_s2_q) begin
                hist_q[0] <= err_s2_q;
                for (int i = 1; i < D_HIST; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
            end
            d_s3_q     <= d_d;
            p_s3_q     <= p_s2_q;
            i_s3_q     <= i_s2_q;
            frwrd_s3_q <= frwrd_s2_q;
            mov_s3_q   <= mov_s2_q;
            vld_s3_q   <= vld_s2_q;
        end
    end

    // ---------------- stage 4: combine terms, steer, clamp ----------------
    logic signed [PID_W-1:0] pid_d;
    logic signed [PID_W-1:0] adj_d;
    logic signed [SPD_W-1:0] frwrd_ext;
    logic signed [SPD_W-1:0] lft_raw;
    logic signed [SPD_W-1:0] rght_raw;
    logic [SAT_W:0]          lft_d;
    logic [SAT_W:0]          rght_d;

    always_comb begin
        pid_d     = PID_W'(p_s3_q >>> 1) + PID_W'(i_s3_q) + PID_W'(d_s3_q);
        adj_d     = pid_d >>> 3;
        frwrd_ext = $signed({{(SPD_W-SAT_W){1'b0}}, frwrd_s3_q});
        lft_raw   = frwrd_ext + SPD_W'(adj_d);
        rght_raw  = frwrd_ext - SPD_W'(adj_d);

        if (lft_raw < 0)             lft_d = '0;
        else if (lft_raw > SPD_MAX)  lft_d = SPD_MAX[SAT_W:0];
        else                         lft_d = lft_raw[SAT_W:0];

        if (rght_raw < 0)            rght_d = '0;
        else if (rght_raw > SPD_MAX) rght_d = SPD_MAX[SAT_W:0];
        else                         rght_d = rght_raw[SAT_W:0];

        if (!mov_s3_q) begin
            lft_d  = '0;
            rght_d = '0;
        end
    end

    logic [SAT_W:0] lft_q;
    logic [SAT_W:0] rght_q;
    logic           out_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q     <= '0;
            rght_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            out_vld_q <= vld_s3_q & mov_s3_q;
        end
    end

    assign pid_io.lft_spd  = lft_q;
    assign pid_io.rght_spd = rght_q;
    assign pid_io.out_vld  = out_vld_q;

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// Bench for pid_ctrl_gen: directed steps plus a random stream against an integer reference model.
// A second instance with clamping anti-windup sees the same stimulus for the windup check.
module tb_pid_ctrl_gen;

    localparam int ERR_W = 12;
    localparam int SAT_W = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pid_ctrl_gen_if #(.ERR_W(ERR_W), .SAT_W(SAT_W)) a_if ();
    pid_ctrl_gen_if #(.ERR_W(ERR_W), .SAT_W(SAT_W)) b_if ();

    assign b_if.moving  = a_if.moving;
    assign b_if.err_vld = a_if.err_vld;
    assign b_if.error   = a_if.error;
    assign b_if.frwrd   = a_if.frwrd;
    assign b_if.kp      = a_if.kp;
    assign b_if.kd      = a_if.kd;

    pid_ctrl_gen #(.ANTIWIND(0)) dut    (.clk(clk), .rst_n(rst_n), .pid_io(a_if));
    pid_ctrl_gen #(.ANTIWIND(1)) dut_aw (.clk(clk), .rst_n(rst_n), .pid_io(b_if));

    typedef struct {
        int l;
        int r;
        int v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_integ;
    int   m_hist[3];

    function automatic int clip(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference for the default parameter set, hold-on-overflow integrator.
    function automatic exp_t model(int err, int fw, int kp, int kd, bit mv, bit vld);
        exp_t e;
        int es, p, s, it, d, ds, dterm, pid, adj;
        es = clip(err, -512, 511);
        p  = es * kp;
        if (!mv) begin
            m_integ = 0;
        end else if (vld) begin
            s = m_integ + es;
            if (s <= 16383 && s >= -16384) m_integ = s;
        end
        it = m_integ >>> 6;
        d  = es - m_hist[2];
        if (d > 511) d -= 1024;
        else if (d < -512) d += 1024;
        ds    = clip(d, -128, 127);
        dterm = ds * kd;
        if (vld) begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = es;
        end
        pid = (p >>> 1) + it + dterm;
        adj = pid >>> 3;
        e.l = mv ? clip(fw + adj, 0, 1023) : 0;
        e.r = mv ? clip(fw - adj, 0, 1023) : 0;
        e.v = (vld && mv) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(int err, int fw, int kp, int kd, bit mv, bit vld);
        exp_t e;
        a_if.error   = ERR_W'(err);
        a_if.frwrd   = SAT_W'(fw);
        a_if.kp      = 6'(kp);
        a_if.kd      = 5'(kd);
        a_if.moving  = mv;
        a_if.err_vld = vld;
        e = model(err, fw, kp, kd, mv, vld);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 4) begin
            e = q.pop_front();
            chk("sb_lft",  int'(a_if.lft_spd),  e.l);
            chk("sb_rght", int'(a_if.rght_spd), e.r);
            chk("sb_vld",  int'(a_if.out_vld),  e.v);
        end
    endtask

    task automatic idle(int fw, int n);
        for (int i = 0; i < n; i++) step(0, fw, 16, 7, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_lft",  int'(a_if.lft_spd),  0);
        chk("rst_rght", int'(a_if.rght_spd), 0);
        chk("rst_vld",  int'(a_if.out_vld),  0);
        q.delete();
        m_integ = 0;
        foreach (m_hist[i]) m_hist[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        a_if.error   = '0;
        a_if.frwrd   = '0;
        a_if.kp      = 6'd16;
        a_if.kd      = 5'd7;
        a_if.moving  = 1'b0;
        a_if.err_vld = 1'b0;
        m_integ      = 0;
        foreach (m_hist[i]) m_hist[i] = 0;
        #2;
        do_reset();

        // Single positive sample, saturated.
        step(12'h7FF, 'h100, 16, 7, 1'b1, 1'b1);
        idle('h100, 3);
        chk("pos_lft",  int'(a_if.lft_spd),  'h36F);
        chk("pos_rght", int'(a_if.rght_spd), 0);
        chk("pos_vld",  int'(a_if.out_vld),  1);
        idle('h100, 1);
        chk("pos_vld_drop", int'(a_if.out_vld), 0);

        // Mid-stream reset, then the same sample must give the fresh-start result.
        step(300, 'h100, 16, 7, 1'b1, 1'b1);
        step(-200, 'h100, 16, 7, 1'b1, 1'b1);
        #3;
        do_reset();
        step(12'h7FF, 'h100, 16, 7, 1'b1, 1'b1);
        idle('h100, 3);
        chk("rst_again_lft", int'(a_if.lft_spd), 'h36F);

        // Single negative sample, fresh start.
        do_reset();
        step(-2048, 'h3F0, 16, 7, 1'b1, 1'b1);
        idle('h3F0, 3);
        chk("neg_lft",  int'(a_if.lft_spd),  'h17F);
        chk("neg_rght", int'(a_if.rght_spd), 'h3FF);

        // Windup: 32 samples of 511 reach 16352, and the 33rd overflows.
        do_reset();
        for (int i = 0; i < 32; i++) step('h1FF, 'h200, 16, 7, 1'b1, 1'b1);
        idle('h200, 1);
        chk("wind32_hold",  int'(dut.integ_q),    16352);
        chk("wind32_clamp", int'(dut_aw.integ_q), 16352);
        step('h1FF, 'h200, 16, 7, 1'b1, 1'b1);
        idle('h200, 1);
        chk("wind33_hold",  int'(dut.integ_q),    16352);
        chk("wind33_clamp", int'(dut_aw.integ_q), 16383);
        idle('h200, 2);

        // Derivative depth 3 with gaps: 40 is compared against 10, so D = 30*7.
        do_reset();
        step(10, 'h100, 16, 7, 1'b1, 1'b1);
        idle('h100, 1);
        step(20, 'h100, 16, 7, 1'b1, 1'b1);
        idle('h100, 2);
        step(30, 'h100, 16, 7, 1'b1, 1'b1);
        idle('h100, 1);
        step(40, 'h100, 16, 7, 1'b1, 1'b1);
        idle('h100, 3);
        chk("depth_lft",  int'(a_if.lft_spd),  322);
        chk("depth_rght", int'(a_if.rght_spd), 190);

        // A single-cycle moving drop clears the integrator and silences that sample.
        do_reset();
        for (int i = 0; i < 5; i++) step(100, 'h180, 16, 7, 1'b1, 1'b1);
        step(100, 'h180, 16, 7, 1'b0, 1'b1);
        step(100, 'h180, 16, 7, 1'b1, 1'b1);
        chk("drop_integ0", int'(dut.integ_q), 0);
        step(100, 'h180, 16, 7, 1'b1, 1'b1);
        chk("drop_integ_restart", int'(dut.integ_q), 100);
        idle('h180, 1);
        chk("drop_lft",  int'(a_if.lft_spd),  0);
        chk("drop_rght", int'(a_if.rght_spd), 0);
        chk("drop_vld",  int'(a_if.out_vld),  0);
        idle('h180, 3);

        // Random stream with per-sample gains and gaps.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 10)),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) != 0));
        end
        idle('h100, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
